// File: rtl/mul_div_scheduler_pkg.sv
// Shared types for the HI/LO multiply/divide scheduler.
// MulDivOp is also carried on the ID decode bus.
package mul_div_scheduler_params;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } MulDivOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } SchedulerState;

    function automatic logic is_mul_op(MulDivOp op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(MulDivOp op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_scheduler_if.sv
// EX-to-scheduler request handshake.
interface mul_div_scheduler_if;
    import mul_div_scheduler_params::*;

    logic              req_valid;
    MulDivOp           req_op;
    logic [DATA_W-1:0] req_src1;
    logic [DATA_W-1:0] req_src2;
    logic              req_ready;

    modport master (output req_valid, req_op, req_src1, req_src2, input req_ready);
    modport slave  (input req_valid, req_op, req_src1, req_src2, output req_ready);
endinterface

// File: rtl/mul_div_scheduler_hi_lo_register.sv
// Architectural HI/LO pair with independent write enables.
module hi_lo_register
    import mul_div_scheduler_params::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         hi_we,
    input  logic [W-1:0] hi_d,
    input  logic         lo_we,
    input  logic [W-1:0] lo_d,
    output logic [W-1:0] hi_q,
    output logic [W-1:0] lo_q
);

    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (hi_we) r_hi <= hi_d;
            if (lo_we) r_lo <= lo_d;
        end
    end

    assign hi_q = r_hi;
    assign lo_q = r_lo;

endmodule

// File: rtl/mul_div_scheduler.sv
// Launches multiplier/divider for EX requests, waits out the result and
// commits it to HI/LO; a WB flush abandons in-flight work without a write.
module mul_div_scheduler
    import mul_div_scheduler_params::*;
#(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mul_div_scheduler_if.slave    req_if,
    input  logic                  flush,
    output logic                  mul_launch,
    output logic                  mul_signed,
    output logic [DATA_W-1:0]     mul_input1,
    output logic [DATA_W-1:0]     mul_input2,
    input  logic [2*DATA_W-1:0]   mul_result,
    output logic                  div_start,
    output logic                  div_signed,
    output logic [DATA_W-1:0]     div_dividend,
    output logic [DATA_W-1:0]     div_divisor,
    output logic                  div_cancel,
    input  logic                  div_done,
    input  logic [DATA_W-1:0]     div_quotient,
    input  logic [DATA_W-1:0]     div_remainder,
    output logic [DATA_W-1:0]     hi_value,
    output logic [DATA_W-1:0]     lo_value,
    output logic                  busy
);

    SchedulerState     r_state;
    SchedulerState     w_state_next;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_req_mul;
    logic              w_req_div;
    logic              w_mul_last;
    logic              w_hi_we;
    logic              w_lo_we;
    logic [DATA_W-1:0] w_hi_d;
    logic [DATA_W-1:0] w_lo_d;

    // A request is only taken in IDLE and never alongside a flush.
    assign w_accept   = req_if.req_valid && (r_state == IDLE) && !flush;
    assign w_req_mul  = is_mul_op(req_if.req_op);
    assign w_req_div  = is_div_op(req_if.req_op);
    assign w_mul_last = (r_count == CNT_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_req_mul)      w_state_next = MUL;
                else if (w_accept && w_req_div) w_state_next = DIV;
            end
            MUL:     if (flush || w_mul_last) w_state_next = IDLE;
            DIV:     if (flush || div_done)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Counter reads MUL_LATENCY in the first MUL cycle; the commit happens at 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept && w_req_mul) begin
            r_count <= CNT_W'(MUL_LATENCY);
        end else if (r_state == MUL) begin
            r_count <= (flush || w_mul_last) ? '0 : r_count - CNT_W'(1);
        end
    end

    always_comb begin
        req_if.req_ready = (r_state == IDLE) && !flush;
        busy             = (r_state != IDLE);
        mul_launch       = 1'b0;
        mul_signed       = 1'b0;
        mul_input1       = req_if.req_src1;
        mul_input2       = req_if.req_src2;
        div_start        = 1'b0;
        div_signed       = 1'b0;
        div_dividend     = req_if.req_src1;
        div_divisor      = req_if.req_src2;
        div_cancel       = 1'b0;
        w_hi_we          = 1'b0;
        w_lo_we          = 1'b0;
        w_hi_d           = req_if.req_src1;
        w_lo_d           = req_if.req_src1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (req_if.req_op)
                        OP_MULT:  begin mul_launch = 1'b1; mul_signed = 1'b1; end
                        OP_MULTU: mul_launch = 1'b1;
                        OP_DIV:   begin div_start = 1'b1; div_signed = 1'b1; end
                        OP_DIVU:  div_start = 1'b1;
                        OP_MTHI:  w_hi_we = 1'b1;
                        OP_MTLO:  w_lo_we = 1'b1;
                        default:  ;
                    endcase
                end
            end
            MUL: begin
                if (!flush && w_mul_last) begin
                    w_hi_we = 1'b1;
                    w_lo_we = 1'b1;
                    w_hi_d  = mul_result[2*DATA_W-1:DATA_W];
                    w_lo_d  = mul_result[DATA_W-1:0];
                end
            end
            DIV: begin
                if (flush) begin
                    div_cancel = 1'b1;
                end else if (div_done) begin
                    w_hi_we = 1'b1;
                    w_lo_we = 1'b1;
                    w_hi_d  = div_remainder;
                    w_lo_d  = div_quotient;
                end
            end
            default: ;
        endcase
    end

    hi_lo_register #(.W(DATA_W)) u_hi_lo (
        .clock (clock),
        .reset (reset),
        .hi_we (w_hi_we),
        .hi_d  (w_hi_d),
        .lo_we (w_lo_we),
        .lo_d  (w_lo_d),
        .hi_q  (hi_value),
        .lo_q  (lo_value)
    );

endmodule

// File: tb/tb_mul_div_scheduler.sv
// Bench for mul_div_scheduler: behavioural multiplier/divider around the DUT
// and a HI/LO reference model updated from the operation semantics.
module tb_mul_div_scheduler;
    import mul_div_scheduler_params::*;

    localparam int unsigned L = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        mul_launch, mul_signed;
    logic [31:0] mul_input1, mul_input2;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_cancel, div_done;
    logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic [31:0] hi_value, lo_value;
    logic        busy;

    always #5 clock = ~clock;

    mul_div_scheduler_if rif ();

    mul_div_scheduler #(.MUL_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .req_if(rif), .flush(flush),
        .mul_launch(mul_launch), .mul_signed(mul_signed),
        .mul_input1(mul_input1), .mul_input2(mul_input2), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_cancel(div_cancel), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .hi_value(hi_value), .lo_value(lo_value), .busy(busy)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          g_dlat  = 1;
    logic        mul_pend = 1'b0, div_pend = 1'b0;
    int          mul_cyc, div_cyc;
    logic [63:0] mul_prod;
    logic [31:0] div_q_m, div_r_m;
    logic [31:0] m_hi = '0, m_lo = '0;

    function automatic logic [63:0] ref_mul(logic s, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(sa * sb);
    endfunction

    task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Advance one cycle: environment observes strobes mid-cycle, then drives unit results.
    task automatic tick();
        @(negedge clock);
        if (mul_launch) begin
            mul_pend = 1'b1;
            mul_cyc  = cyc + int'(L);
            mul_prod = ref_mul(mul_signed, mul_input1, mul_input2);
        end
        if (div_cancel || div_done) div_pend = 1'b0;
        if (div_start) begin
            div_pend = 1'b1;
            div_cyc  = cyc + g_dlat;
            ref_div(div_signed, div_dividend, div_divisor, div_q_m, div_r_m);
        end
        if (!reset) begin mul_pend = 1'b0; div_pend = 1'b0; end
        @(posedge clock);
        #1;
        cyc++;
        mul_result = (mul_pend && cyc == mul_cyc) ? mul_prod : {$urandom, $urandom};
        if (mul_pend && cyc == mul_cyc) mul_pend = 1'b0;
        div_done      = div_pend && (cyc == div_cyc);
        div_quotient  = div_done ? div_q_m : $urandom;
        div_remainder = div_done ? div_r_m : $urandom;
    endtask

    // One request from accept to commit (or flush); fl_at is the flush cycle offset, 0 = none.
    task automatic run_op(input MulDivOp op, input logic [31:0] a, input logic [31:0] b,
                          input int dlat, input int fl_at, input bit spur_t, input string tag);
        logic        ism, isd;
        logic [31:0] e_hi, e_lo, q, r;
        int          nlat;
        ism = (op == OP_MULT) || (op == OP_MULTU);
        isd = (op == OP_DIV) || (op == OP_DIVU);
        g_dlat = dlat;
        rif.req_valid = 1'b1; rif.req_op = op; rif.req_src1 = a; rif.req_src2 = b;
        flush = 1'b0;
        if (spur_t) begin div_done = 1'b1; div_quotient = $urandom; div_remainder = $urandom; end
        #1;
        n_total++;
        if (rif.req_ready !== 1'b1 || busy !== 1'b0 || mul_launch !== ism || div_start !== isd) begin
            n_bad++;
            $display("FAIL %s accept: ready=%b busy=%b launch=%b start=%b want 1 0 %b %b",
                     tag, rif.req_ready, busy, mul_launch, div_start, ism, isd);
        end
        if (ism) begin
            n_total++;
            if (mul_signed !== (op == OP_MULT) || mul_input1 !== a || mul_input2 !== b) begin
                n_bad++;
                $display("FAIL %s mul_operands: s=%b %h %h want %b %h %h", tag,
                         mul_signed, mul_input1, mul_input2, op == OP_MULT, a, b);
            end
        end
        if (isd) begin
            n_total++;
            if (div_signed !== (op == OP_DIV) || div_dividend !== a || div_divisor !== b) begin
                n_bad++;
                $display("FAIL %s div_operands: s=%b %h %h want %b %h %h", tag,
                         div_signed, div_dividend, div_divisor, op == OP_DIV, a, b);
            end
        end
        e_hi = m_hi; e_lo = m_lo;
        if (ism) {e_hi, e_lo} = ref_mul(op == OP_MULT, a, b);
        if (isd) begin ref_div(op == OP_DIV, a, b, q, r); e_lo = q; e_hi = r; end
        if (op == OP_MTHI) e_hi = a;
        if (op == OP_MTLO) e_lo = a;
        nlat = ism ? int'(L) : (isd ? dlat : 0);
        for (int k = 1; k <= nlat; k++) begin
            tick();
            rif.req_valid = 1'b0;
            flush = (k == fl_at);
            #1;
            n_total++;
            if (busy !== 1'b1 || rif.req_ready !== 1'b0 || mul_launch !== 1'b0 || div_start !== 1'b0
                || div_cancel !== (isd && k == fl_at)) begin
                n_bad++;
                $display("FAIL %s pending_k%0d: busy=%b ready=%b launch=%b start=%b cancel=%b want 1 0 0 0 %b",
                         tag, k, busy, rif.req_ready, mul_launch, div_start, div_cancel, isd && k == fl_at);
            end
            if (k == fl_at) begin
                tick();
                flush = 1'b0;
                #1;
                n_total++;
                if (busy !== 1'b0 || hi_value !== m_hi || lo_value !== m_lo) begin
                    n_bad++;
                    $display("FAIL %s flushed: busy=%b hi=%h lo=%h want 0 %h %h",
                             tag, busy, hi_value, lo_value, m_hi, m_lo);
                end
                return;
            end
        end
        tick();
        rif.req_valid = 1'b0;
        flush = 1'b0;
        #1;
        m_hi = e_hi; m_lo = e_lo;
        n_total++;
        if (hi_value !== m_hi || lo_value !== m_lo || busy !== 1'b0 || rif.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s commit: hi=%h lo=%h busy=%b ready=%b want %h %h 0 1",
                     tag, hi_value, lo_value, busy, rif.req_ready, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; rif.req_valid = 1'b0; rif.req_op = OP_MULT;
        rif.req_src1 = '0; rif.req_src2 = '0; div_done = 1'b0; mul_result = '0;
        div_quotient = '0; div_remainder = '0;
        tick(); tick();
        n_total++;
        if (hi_value !== 32'd0 || lo_value !== 32'd0 || busy !== 1'b0 || rif.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b ready=%b", hi_value, lo_value, busy, rif.req_ready);
        end
        reset = 1'b1;
        run_op(OP_MTHI, 32'hCAFE_F00D, 32'd0, 0, 0, 0, "pre_mthi");
        run_op(OP_MTLO, 32'h0BAD_BEEF, 32'd0, 0, 0, 0, "pre_mtlo");
        // Start a divide and pull reset in the middle of it.
        g_dlat = 30;
        rif.req_valid = 1'b1; rif.req_op = OP_DIV; rif.req_src1 = 32'd1000; rif.req_src2 = 32'd3;
        tick();
        rif.req_valid = 1'b0;
        tick(); tick();
        #1 reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        n_total++;
        if (hi_value !== 32'd0 || lo_value !== 32'd0 || busy !== 1'b0 || rif.req_ready !== 1'b1
            || div_cancel !== 1'b0 || div_start !== 1'b0 || mul_launch !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_div: hi=%h lo=%h busy=%b ready=%b cancel=%b start=%b launch=%b",
                     hi_value, lo_value, busy, rif.req_ready, div_cancel, div_start, mul_launch);
        end
        tick(); tick();
        reset = 1'b1;
        run_op(OP_MTLO, 32'h1234_5678, 32'd0, 0, 0, 0, "mtlo_after_reset");
        n_total++;
        if (lo_value !== 32'h1234_5678 || hi_value !== 32'd0) begin
            n_bad++;
            $display("FAIL mtlo_value: hi=%h lo=%h want 00000000 12345678", hi_value, lo_value);
        end
    endtask

    task automatic test_signed_mult();
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, "mult_signed");
        n_total++;
        if (hi_value !== 32'hFFFF_FFFF || lo_value !== 32'hFFFF_FFFA) begin
            n_bad++;
            $display("FAIL mult_value: hi=%h lo=%h want ffffffff fffffffa", hi_value, lo_value);
        end
    endtask

    task automatic test_divu();
        run_op(OP_DIVU, 32'd100, 32'd7, 33, 0, 1, "divu");
        n_total++;
        if (lo_value !== 32'd14 || hi_value !== 32'd2) begin
            n_bad++;
            $display("FAIL divu_value: hi=%0d lo=%0d want 2 14", hi_value, lo_value);
        end
    endtask

    task automatic test_flush_div();
        run_op(OP_DIV, $urandom, 32'd9, 20, 5, 0, "flush_div");
        tick();
        div_done = 1'b1; div_quotient = $urandom; div_remainder = $urandom;
        #1;
        tick();
        #1;
        n_total++;
        if (busy !== 1'b0 || hi_value !== m_hi || lo_value !== m_lo) begin
            n_bad++;
            $display("FAIL spurious_done: busy=%b hi=%h lo=%h want 0 %h %h", busy, hi_value, lo_value, m_hi, m_lo);
        end
    endtask

    task automatic test_flush_collide();
        logic [31:0] hold_hi;
        run_op(OP_DIVU, 32'd5000, 32'd13, 6, 6, 0, "flush_with_done");
        run_op(OP_MULT, $urandom, $urandom, 0, int'(L), 0, "flush_last_mul");
        hold_hi = m_hi;
        rif.req_valid = 1'b1; rif.req_op = OP_MTHI; rif.req_src1 = ~hold_hi;
        flush = 1'b1;
        #1;
        n_total++;
        if (rif.req_ready !== 1'b0 || mul_launch !== 1'b0 || div_start !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_req_ready: ready=%b launch=%b start=%b want 0 0 0",
                     rif.req_ready, mul_launch, div_start);
        end
        tick();
        rif.req_valid = 1'b0; flush = 1'b0;
        #1;
        n_total++;
        if (hi_value !== hold_hi || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_mthi_dropped: hi=%h busy=%b want %h 0", hi_value, busy, hold_hi);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "multu_b2b");
        n_total++;
        if (hi_value !== 32'hFFFF_FFFE || lo_value !== 32'd1) begin
            n_bad++;
            $display("FAIL multu_value: hi=%h lo=%h want fffffffe 00000001", hi_value, lo_value);
        end
        run_op(OP_MTHI, 32'd5, 32'd0, 0, 0, 0, "mthi_b2b");
        n_total++;
        if (hi_value !== 32'd5 || lo_value !== 32'd1) begin
            n_bad++;
            $display("FAIL mthi_b2b_value: hi=%h lo=%h want 00000005 00000001", hi_value, lo_value);
        end
    endtask

    task automatic test_random();
        MulDivOp     op;
        logic [31:0] a, b;
        int          dl, lat, fl;
        for (int i = 0; i < 60; i++) begin
            op  = MulDivOp'(3'($urandom_range(0, 5)));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            dl  = $urandom_range(1, 10);
            lat = ((op == OP_MULT) || (op == OP_MULTU)) ? int'(L)
                : (((op == OP_DIV) || (op == OP_DIVU)) ? dl : 0);
            fl  = (lat > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
            run_op(op, a, b, dl, fl, 0, $sformatf("rand%0d", i));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
    endtask

    initial begin
        test_reset();
        test_signed_mult();
        test_divu();
        test_flush_div();
        test_flush_collide();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
